// File: rtl/freq_div_pkg.sv
// freq_div_pkg
// Shared definitions for the run-time frequency divider controller:
// FSM state encoding and the default counter width / half-period.
// No ports (package).
`timescale 1ns/1ps
package freq_div_pkg;

    localparam int FD_CNT_W    = 16;
    localparam int FD_DEF_HALF = 49;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/freq_div_ctrl_if.sv
// freq_div_ctrl_if
// Command and configuration bus between the register logic (master)
// and the divider controller (slave).
//   cmd_start  master->slave  single-cycle start request
//   cmd_stop   master->slave  single-cycle stop request
//   cfg_valid  master->slave  new half-period offered
//   cfg_half   master->slave  terminal count, ratio = 2*(cfg_half+1)
//   cfg_ready  slave->master  controller can accept cfg_half
`timescale 1ns/1ps
interface freq_div_ctrl_if import freq_div_pkg::*; #(
    parameter int CNT_W = FD_CNT_W
);

    logic             cmd_start;
    logic             cmd_stop;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_half;

    modport master (
        output cmd_start,
        output cmd_stop,
        output cfg_valid,
        output cfg_half,
        input  cfg_ready
    );

    modport slave (
        input  cmd_start,
        input  cmd_stop,
        input  cfg_valid,
        input  cfg_half,
        output cfg_ready
    );

endinterface

// File: rtl/freq_div_core.sv
// freq_div_core
// Half-period counter, terminal compare, clk_div toggle and tick pulse.
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   enable          count while high; low clears counter, clk_div, tick
//   load, load_half replace the half-period terminal count (half_reg)
//   term            counter at terminal count while enabled (combinational)
//   clk_div         divided clock
//   tick            one-cycle pulse registered with every clk_div edge
`timescale 1ns/1ps
module freq_div_core import freq_div_pkg::*; #(
    parameter int CNT_W    = FD_CNT_W,
    parameter int DEF_HALF = FD_DEF_HALF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] load_half,
    output logic             term,
    output logic             clk_div,
    output logic             tick
);

    logic [CNT_W-1:0] half_reg;
    logic [CNT_W-1:0] counter;

    // Equality is enough: the counter restarts at every terminal count and
    // half_reg only changes at that same edge, so counter never exceeds it.
    assign term = enable && (counter == half_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_reg <= CNT_W'(DEF_HALF);
        end else if (load) begin
            half_reg <= load_half;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else if (!enable) begin
            counter <= '0;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else if (term) begin
            counter <= '0;
            clk_div <= ~clk_div;
            tick    <= 1'b1;
        end else begin
            counter <= counter + 1'b1;
            tick    <= 1'b0;
        end
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl
// Run-time controller for the frequency divider: run/stop sequencing,
// programmable half-period and a ratio change applied only at a
// half-period boundary.
// Optional feature macro: FREQ_DIV_CNT_EN adds the tick_cnt port.
// Ports:
//   clk, reset  system clock, asynchronous active-low reset
//   ctrl        freq_div_ctrl_if.slave (cmd_start/cmd_stop, cfg handshake)
//   clk_div     divided clock, 50 % duty
//   tick        one-cycle pulse with every clk_div edge
//   busy        state != IDLE (registered)
//   state       current FSM state (IDLE=0, RUN=1, DRAIN=2)
//   tick_cnt    tick pulse count, cleared on entry to RUN (FREQ_DIV_CNT_EN)
`timescale 1ns/1ps
module freq_div_ctrl import freq_div_pkg::*; #(
    parameter int CNT_W    = FD_CNT_W,
    parameter int DEF_HALF = FD_DEF_HALF
) (
    input  logic                clk,
    input  logic                reset,
    freq_div_ctrl_if.slave      ctrl,
    output logic                clk_div,
    output logic                tick,
    output logic                busy,
    output logic [1:0]          state
`ifdef FREQ_DIV_CNT_EN
    ,
    output logic [15:0]         tick_cnt
`endif
);

    state_t           state_q;
    logic             cfg_ready_q;
    logic             pend_valid;
    logic [CNT_W-1:0] pend_half;
    logic             xfer;
    logic             abort;
    logic             run_en;
    logic             term;
    logic             load_en;
    logic [CNT_W-1:0] load_val;
    logic             start_req;

    assign xfer          = ctrl.cfg_valid && cfg_ready_q;
    assign start_req     = ctrl.cmd_start && !ctrl.cmd_stop;
    // Stopping during the low phase ends at once; the low phase may be cut
    // short but a high phase never is.
    assign abort         = (state_q == RUN) && ctrl.cmd_stop && !clk_div;
    assign run_en        = (state_q != IDLE) && !abort;
    assign ctrl.cfg_ready = cfg_ready_q;
    assign state         = state_q;

    // A value still pending when the divider reaches IDLE (stop during the
    // low phase, or a transfer on the final DRAIN edge) is applied in IDLE
    // so the handshake can never stall.
    always_comb begin
        load_en  = 1'b0;
        load_val = pend_half;
        if (state_q == IDLE) begin
            if (pend_valid) begin
                load_en  = 1'b1;
                load_val = pend_half;
            end else if (xfer) begin
                load_en  = 1'b1;
                load_val = ctrl.cfg_half;
            end
        end else if (term && pend_valid) begin
            load_en  = 1'b1;
            load_val = pend_half;
        end
    end

    freq_div_core #(
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
    ) core (
        .clk       (clk),
        .reset     (reset),
        .enable    (run_en),
        .load      (load_en),
        .load_half (load_val),
        .term      (term),
        .clk_div   (clk_div),
        .tick      (tick)
    );

    // A transfer needs cfg_ready, which is low whenever a value is pending,
    // so accepting and applying never coincide. A transfer on a terminal
    // cycle is stored here and applied at the following terminal count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            cfg_ready_q <= 1'b1;
            pend_valid  <= 1'b0;
            pend_half   <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (pend_valid) begin
                    pend_valid  <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
            end else begin
                if (term && pend_valid) begin
                    pend_valid  <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
                if (xfer) begin
                    pend_valid  <= 1'b1;
                    pend_half   <= ctrl.cfg_half;
                    cfg_ready_q <= 1'b0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        state_q <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    // If the high phase ends on this very cycle the falling
                    // edge is already happening, so no drain is needed.
                    if (ctrl.cmd_stop) begin
                        if (clk_div && !term) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (term) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef FREQ_DIV_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= 16'd0;
        end else if ((state_q == IDLE) && start_req) begin
            tick_cnt <= 16'd0;
        end else if (term) begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end
`endif

endmodule
